// File: rtl/tl_ul_slave_buffer.sv
// TileLink-UL slave-side buffer: independent registered FIFOs on A and D.
// Every valid/ready/data path toward the slave crossing is cut by a register.
module tl_ul_slave_buffer_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic         busy_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          enq, deq;

  assign in_ready_o  = (cnt_q != FULL);
  assign out_valid_o = (cnt_q != '0);
  assign busy_o      = out_valid_o;
  assign out_data_o  = mem_q[rd_q];
  assign enq         = in_valid_i & in_ready_o;
  assign deq         = out_valid_o & out_ready_i;

  // power-of-two depth lets the pointers wrap by overflow
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (enq) wr_d = wr_q + 1'b1;
    if (deq) rd_d = rd_q + 1'b1;
    unique case ({enq, deq})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_q] <= in_data_i;
  end
endmodule

module tl_ul_slave_buffer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SRC_W  = 1,
  parameter int SIZE_W = 2,
  parameter int DEPTH  = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_a_valid,
  output logic                in_a_ready,
  input  logic [2:0]          in_a_opcode,
  input  logic [2:0]          in_a_param,
  input  logic [SIZE_W-1:0]   in_a_size,
  input  logic [SRC_W-1:0]    in_a_source,
  input  logic [ADDR_W-1:0]   in_a_address,
  input  logic [DATA_W/8-1:0] in_a_mask,
  input  logic [DATA_W-1:0]   in_a_data,
  output logic                out_a_valid,
  input  logic                out_a_ready,
  output logic [2:0]          out_a_opcode,
  output logic [2:0]          out_a_param,
  output logic [SIZE_W-1:0]   out_a_size,
  output logic [SRC_W-1:0]    out_a_source,
  output logic [ADDR_W-1:0]   out_a_address,
  output logic [DATA_W/8-1:0] out_a_mask,
  output logic [DATA_W-1:0]   out_a_data,
  input  logic                in_d_valid,
  output logic                in_d_ready,
  input  logic [2:0]          in_d_opcode,
  input  logic [1:0]          in_d_param,
  input  logic [SIZE_W-1:0]   in_d_size,
  input  logic [SRC_W-1:0]    in_d_source,
  input  logic                in_d_denied,
  input  logic [DATA_W-1:0]   in_d_data,
  input  logic                in_d_corrupt,
  output logic                out_d_valid,
  input  logic                out_d_ready,
  output logic [2:0]          out_d_opcode,
  output logic [1:0]          out_d_param,
  output logic [SIZE_W-1:0]   out_d_size,
  output logic [SRC_W-1:0]    out_d_source,
  output logic                out_d_denied,
  output logic [DATA_W-1:0]   out_d_data,
  output logic                out_d_corrupt,
  output logic                busy
);
  localparam int AW = 6 + SIZE_W + SRC_W + ADDR_W + DATA_W/8 + DATA_W;
  localparam int DW = 5 + SIZE_W + SRC_W + 1 + DATA_W + 1;

  logic [AW-1:0] a_in, a_out;
  logic [DW-1:0] d_in, d_out;
  logic          a_busy, d_busy;

  assign a_in = {in_a_opcode, in_a_param, in_a_size, in_a_source,
                 in_a_address, in_a_mask, in_a_data};
  assign {out_a_opcode, out_a_param, out_a_size, out_a_source,
          out_a_address, out_a_mask, out_a_data} = a_out;

  assign d_in = {in_d_opcode, in_d_param, in_d_size, in_d_source,
                 in_d_denied, in_d_data, in_d_corrupt};
  assign {out_d_opcode, out_d_param, out_d_size, out_d_source,
          out_d_denied, out_d_data, out_d_corrupt} = d_out;

  assign busy = a_busy | d_busy;

  tl_ul_slave_buffer_fifo #(.W(AW), .DEPTH(DEPTH)) u_a (
    .clk_i       (clock),
    .rst_ni      (reset_n),
    .in_valid_i  (in_a_valid),
    .in_ready_o  (in_a_ready),
    .in_data_i   (a_in),
    .out_valid_o (out_a_valid),
    .out_ready_i (out_a_ready),
    .out_data_o  (a_out),
    .busy_o      (a_busy)
  );

  tl_ul_slave_buffer_fifo #(.W(DW), .DEPTH(DEPTH)) u_d (
    .clk_i       (clock),
    .rst_ni      (reset_n),
    .in_valid_i  (in_d_valid),
    .in_ready_o  (in_d_ready),
    .in_data_i   (d_in),
    .out_valid_o (out_d_valid),
    .out_ready_i (out_d_ready),
    .out_data_o  (d_out),
    .busy_o      (d_busy)
  );
endmodule
